// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg: shared types and constants for the FIFO read scheduler
package fifo_sched_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int OBUF_DEPTH = 4;
  localparam int CH_W = 2;
  localparam int DATA_W = 8;
  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } obuf_entry_t;
endpackage

// File: rtl/fifo_rd_obuf.sv
// fifo_rd_obuf: 4-deep output buffer of tagged words with simultaneous push/pop
module fifo_rd_obuf
  import fifo_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rd_rstn,
  input  logic        push,
  input  obuf_entry_t din,
  input  logic        pop,
  output obuf_entry_t dout,
  output logic [2:0]  occ
);
  obuf_entry_t mem_q [OBUF_DEPTH];
  obuf_entry_t mem_d [OBUF_DEPTH];
  logic [1:0] wp_q, wp_d, rp_q, rp_d;
  logic [2:0] occ_q, occ_d;
  logic do_pop;
  // pointer/occupancy update; a pop of an empty buffer is ignored
  always_comb begin
    do_pop = pop && occ_q != 3'd0;
    mem_d = mem_q;
    if (push) mem_d[wp_q] = din;
    wp_d = push ? wp_q + 2'd1 : wp_q;
    rp_d = do_pop ? rp_q + 2'd1 : rp_q;
    occ_d = occ_q + 3'(push) - 3'(do_pop);
    dout = mem_q[rp_q];
    occ = occ_q;
  end
  // storage needs no reset: it is only observed through occupancy
  always_ff @(posedge clk)
    mem_q <= mem_d;
  // pointers and occupancy
  always_ff @(posedge clk or posedge rd_rstn)
    if (rd_rstn) begin
      wp_q <= '0;
      rp_q <= '0;
      occ_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      occ_q <= occ_d;
    end
endmodule

// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched: round-robin burst reader merging N_CH FIFOs into one tagged stream
module fifo_rd_sched
  import fifo_sched_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
)(
  input  logic              clk,
  input  logic              rd_rstn,
  input  logic              en,
  input  logic [N_CH-1:0]   empty,
  input  logic [N_CH-1:0]   almost_empty,
  output logic [N_CH-1:0]   rd,
  input  logic [N_CH*DW-1:0] rd_data,
  input  logic [N_CH-1:0]   rd_data_vld,
  output logic [DW-1:0]     out_data,
  output logic [1:0]        out_ch,
  output logic              out_vld,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_unexp
);
  state_t state_q, state_d;
  logic [CH_W-1:0] grant_q, grant_d, last_q, last_d, win, idx, inflight_ch_q, inflight_ch_d;
  logic [3:0] beat_q, beat_d;
  logic inflight_q, inflight_d, err_q, err_d, any_req, issue, push;
  logic [N_CH-1:0] rd_prev_q, rd_prev_d, exp_vld;
  logic [2:0] occ;
  obuf_entry_t din, dout;
  // round-robin winner: nearest non-empty channel after last_grant wins
  always_comb begin
    win = last_q;
    idx = '0;
    any_req = 1'b0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = CH_W'((int'(last_q) + i) % N_CH);
      if (!empty[idx]) begin
        win = idx;
        any_req = 1'b1;
      end
    end
  end
  // FSM and issue rule; shallow FIFOs need a gap cycle between reads
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    beat_d = beat_q;
    issue = 1'b0;
    if (state_q == IDLE) begin
      if (en && any_req) begin
        state_d = GRANT;
        grant_d = win;
        last_d = win;
        beat_d = '0;
      end
    end else begin
      issue = !empty[grant_q] && ({1'b0, occ} + 4'(inflight_q) < 4'd4)
              && (!almost_empty[grant_q] || !rd_prev_q[grant_q]);
      beat_d = beat_q + 4'(issue);
      if (!en || empty[grant_q] || beat_d == 4'(BURST)) state_d = IDLE;
    end
    rd = issue ? (N_CH'(1) << grant_q) : '0;
    rd_prev_d = rd;
    inflight_d = issue;
    inflight_ch_d = issue ? grant_q : inflight_ch_q;
  end
  // return-data steering, unexpected-valid detection and output view
  always_comb begin
    exp_vld = inflight_q ? (N_CH'(1) << inflight_ch_q) : '0;
    push = |(rd_data_vld & exp_vld);
    err_d = err_q | (|(rd_data_vld & ~exp_vld));
    din.ch = inflight_ch_q;
    din.data = DATA_W'(rd_data >> (DW * int'(inflight_ch_q)));
    out_vld = occ != 3'd0;
    out_data = out_vld ? dout.data : '0;
    out_ch = out_vld ? dout.ch : '0;
    busy = state_q != IDLE || inflight_q || out_vld;
    err_unexp = err_q;
  end
  // scheduler state
  always_ff @(posedge clk or posedge rd_rstn)
    if (rd_rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= CH_W'(N_CH - 1);
      beat_q <= '0;
      inflight_q <= 1'b0;
      inflight_ch_q <= '0;
      rd_prev_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      beat_q <= beat_d;
      inflight_q <= inflight_d;
      inflight_ch_q <= inflight_ch_d;
      rd_prev_q <= rd_prev_d;
      err_q <= err_d;
    end
  fifo_rd_obuf u_obuf (
    .clk     (clk),
    .rd_rstn (rd_rstn),
    .push    (push),
    .din     (din),
    .pop     (out_vld & out_ready),
    .dout    (dout),
    .occ     (occ)
  );
endmodule

// File: tb/tb_fifo_rd_sched.sv
// tb_fifo_rd_sched: queue-based FIFO/stream model checked against the scheduler every cycle
module tb_fifo_rd_sched;
  typedef struct packed {logic [1:0] ch; logic [7:0] d;} ent_t;
  logic clk = 1'b0;
  logic rd_rstn = 1'b0;
  logic en = 1'b0;
  logic [3:0] empty, almost_empty, rd, rd_data_vld;
  logic [31:0] rd_data;
  logic [7:0] out_data;
  logic [1:0] out_ch;
  logic out_vld, out_ready, busy, err_unexp;
  logic [7:0] fq [4][$];
  logic [7:0] wq [4][$];
  ent_t oq [$];
  int th [4];
  int pc [4];
  logic [3:0] rd_s, prev_rd;
  logic [7:0] od_s, ret_d;
  logic [1:0] oc_s, ret_ch;
  logic pop_s, busy_s, ret_valid, inj, m_err;
  int cyc, vectors, miscompares;

  fifo_rd_sched #(.N_CH(4), .DW(8), .BURST(4)) dut (
    .clk(clk), .rd_rstn(rd_rstn), .en(en), .empty(empty), .almost_empty(almost_empty),
    .rd(rd), .rd_data(rd_data), .rd_data_vld(rd_data_vld), .out_data(out_data),
    .out_ch(out_ch), .out_vld(out_vld), .out_ready(out_ready), .busy(busy), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void upd_flags();
    for (int k = 0; k < 4; k++) begin
      empty[k] = fq[k].size() == 0;
      almost_empty[k] = fq[k].size() <= th[k];
    end
  endfunction

  function automatic bit pending();
    bit p = busy_s || ret_valid || oq.size() != 0;
    for (int k = 0; k < 4; k++) p |= fq[k].size() != 0;
    return p;
  endfunction

  task automatic write_word(int k, logic [7:0] d);
    fq[k].push_back(d);
    wq[k].push_back(d);
  endtask

  task automatic check_rst(string nm);
    chk({nm, "_rd"}, rd, 0);
    chk({nm, "_out_vld"}, out_vld, 0);
    chk({nm, "_out_data"}, out_data, 0);
    chk({nm, "_out_ch"}, out_ch, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err_unexp, 0);
  endtask

  task automatic do_reset(string nm);
    rd_rstn = 1'b1;
    en = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fq[k].delete();
      wq[k].delete();
      pc[k] = 0;
      th[k] = 0;
    end
    oq.delete();
    m_err = 1'b0;
    prev_rd = '0;
    ret_valid = 1'b0;
    inj = 1'b0;
    rd_data_vld = '0;
    rd_data = '0;
    busy_s = 1'b0;
    upd_flags();
    #1 check_rst(nm);
    repeat (2) @(posedge clk);
    #1 rd_rstn = 1'b0;
  endtask

  // per-cycle comparison of DUT outputs against the stream model and the read rules
  task automatic check_cycle();
    chk("out_vld", out_vld, oq.size() != 0);
    if (oq.size() != 0) begin
      chk("out_data", out_data, oq[0].d);
      chk("out_ch", out_ch, oq[0].ch);
    end
    chk("err_unexp", err_unexp, m_err);
    chk("rd_onehot", $countones(rd) <= 1, 1);
    if (rd != 0) begin
      chk("rd_nonempty", |(rd & empty), 0);
      chk("rd_ae_gap", |(rd & almost_empty & prev_rd), 0);
      chk("rd_room", (oq.size() + (prev_rd != 0 ? 1 : 0)) < 4, 1);
      chk("busy_grant", busy, 1);
    end
    if (oq.size() != 0 || prev_rd != 0) chk("busy", busy, 1);
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    rd_s = rd;
    pop_s = out_vld && out_ready;
    od_s = out_data;
    oc_s = out_ch;
    busy_s = busy;
    @(posedge clk);
    if (pop_s) begin
      if (oq.size() != 0) void'(oq.pop_front());
      chk("ch_order_avail", wq[oc_s].size() != 0, 1);
      if (wq[oc_s].size() != 0) chk("ch_order", od_s, wq[oc_s].pop_front());
      pc[oc_s]++;
    end
    if (ret_valid) oq.push_back(ent_t'{ch: ret_ch, d: ret_d});
    if (inj) m_err = 1'b1;
    prev_rd = rd_s;
    #1;
    ret_valid = 1'b0;
    inj = 1'b0;
    rd_data_vld = '0;
    rd_data = $urandom;
    for (int k = 0; k < 4; k++)
      if (rd_s[k] && fq[k].size() != 0) begin
        ret_d = fq[k].pop_front();
        ret_ch = 2'(k);
        ret_valid = 1'b1;
        rd_data[k*8 +: 8] = ret_d;
        rd_data_vld[k] = 1'b1;
      end
    upd_flags();
    cyc++;
  endtask

  task automatic drain(string nm, int bound);
    int n = 0;
    while (n < bound && pending()) begin
      tick();
      n++;
    end
    chk(nm, pending(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] tr;
    logic [7:0] b;
    int nrd, written, n, k;
    bit late_rd, vld_ok;
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    out_ready = 1'b1;
    rd_data_vld = '0;
    rd_data = '0;
    for (int i = 0; i < 4; i++) th[i] = 0;
    upd_flags();
    #3 do_reset("por");

    // single channel, 10 words, almost_empty once 3 or fewer remain
    th[0] = 3;
    for (int i = 0; i < 10; i++) write_word(0, 8'($urandom));
    upd_flags();
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      tr[i] = rd_s[0];
    end
    chk("single_trace", tr, 16'h55DE);
    drain("single_drain", 200);
    chk("single_count", pc[0], 10);

    // round-robin across four deep channels
    do_reset("rst_rr");
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 8; i++) write_word(c, 8'($urandom));
    upd_flags();
    en = 1'b1;
    for (int c = 0; c < 42; c++) begin
      tick();
      chk("rr_grant", rd_s, (c % 5 == 0 || c >= 40) ? 4'd0 : 4'(1 << ((c / 5) % 4)));
    end
    drain("rr_drain", 200);
    chk("rr_count", pc[0] + pc[1] + pc[2] + pc[3], 32);

    // backpressure on channel 1
    do_reset("rst_bp");
    for (int i = 0; i < 32; i++) write_word(1, 8'($urandom));
    upd_flags();
    out_ready = 1'b0;
    en = 1'b1;
    nrd = 0;
    late_rd = 0;
    vld_ok = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rd_s != 0) nrd++;
      if (c >= 5 && rd_s != 0) late_rd = 1;
      if (c >= 3 && !pop_s && oq.size() == 0) vld_ok = 0;
    end
    chk("bp_reads", nrd, 4);
    chk("bp_rd_stalled", late_rd, 0);
    chk("bp_vld_held", vld_ok && out_vld, 1);
    out_ready = 1'b1;
    drain("bp_drain", 400);
    chk("bp_count", pc[1], 32);

    // shallow channel 2: one read, gap, one read
    do_reset("rst_sh");
    th[2] = 15;
    write_word(2, 8'h5A);
    write_word(2, 8'hC3);
    upd_flags();
    en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      tr[c] = rd_s[2];
      b[c] = busy_s;
    end
    chk("shallow_rd", tr[5:0], 6'b001010);
    chk("shallow_busy_c4", b[4], 1);
    chk("shallow_idle", b[6] | b[7], 0);

    // unexpected return on channel 3
    chk("err_pre", err_unexp, 0);
    rd_data_vld = 4'b1000;
    inj = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    chk("err_sticky", err_unexp, 1);
    chk("err_no_push", out_vld, 0);

    // reset in the middle of a burst
    for (int i = 0; i < 16; i++) write_word(0, 8'($urandom));
    upd_flags();
    out_ready = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    #2;
    chk("mid_pre_rd", rd != 0, 1);
    chk("mid_pre_vld", out_vld, 1);
    chk("mid_pre_err", err_unexp, 1);
    do_reset("mid_rst");

    // random soak
    for (int i = 0; i < 4; i++) th[i] = $urandom_range(0, 3);
    upd_flags();
    en = 1'b1;
    written = 0;
    n = 0;
    while (n < 40000 && (written < 10000 || pending())) begin
      out_ready = $urandom_range(0, 3) != 0;
      en = $urandom_range(0, 19) != 0;
      if (written < 10000) begin
        k = $urandom_range(0, 3);
        if (fq[k].size() < 16) begin
          write_word(k, 8'($urandom));
          written++;
        end
      end
      upd_flags();
      tick();
      n++;
    end
    chk("soak_done", written == 10000 && !pending(), 1);
    chk("soak_count", pc[0] + pc[1] + pc[2] + pc[3], 10000);
    chk("soak_err", err_unexp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fifo_rd_sched.md
# fifo_rd_sched

Read-side scheduler that drains up to four asynchronous FIFOs in the read clock domain and merges them into one tagged output stream. It sits between the read ports of the per-channel `asynfifo` instances and a single downstream consumer. Channels are served round-robin in bursts, and reads are issued only under the FIFOs' empty/almost_empty rules. Returned data passes through a 4-entry output buffer, which gives the downstream consumer ready/valid backpressure.

## Interface
- `N_CH`, 4: number of FIFO channels (2..4).
- `DW`, 8: data width of each FIFO.
- `BURST`, 4: maximum reads per grant (1..15).
- `clk`  in  1: read-domain clock, the same clock as the FIFOs' `rd_clk`.
- `rd_rstn`  in  1: reset, asynchronous, active-high; clock `clk`.
- `en`  in  1: scheduler enable; when low, no new grant is taken.
- `empty`  in  N_CH: per-channel FIFO empty flag.
- `almost_empty`  in  N_CH: per-channel FIFO almost_empty flag.
- `rd`  out  N_CH: per-channel read strobe; at most one bit is set.
- `rd_data`  in  N_CH*DW: per-channel read data; channel k occupies bits [k*DW +: DW].
- `rd_data_vld`  in  N_CH: per-channel read-data valid.
- `out_data`  out  DW: head word of the output buffer.
- `out_ch`  out  2: channel index of `out_data`.
- `out_vld`  out  1: output buffer is non-empty.
- `out_ready`  in  1: downstream accepts; a pop occurs when `out_vld & out_ready`.
- `busy`  out  1: the FSM is not in IDLE, or a read is in flight, or the buffer is non-empty.
- `err_unexp`  out  1: sticky flag; set by a `rd_data_vld` on a channel with no outstanding read.

## Operation
- FSM states and transitions:
  - IDLE → GRANT when `en` is high and any `empty[k]` is low.
    - Winner: the first non-empty channel searching from `last_grant+1` modulo N_CH.
    - On entry the FSM registers `grant`, sets `last_grant = grant` and clears `beat_cnt`.
  - GRANT → IDLE when either of these holds:
    - `beat_cnt == BURST`;
    - the issue rule (below) fails because `empty[grant]` is high.
  - `en` falling during GRANT finishes the current cycle, then the FSM returns to IDLE.
- Issue rule in GRANT: `rd[grant]` is asserted in a cycle only if all of the following hold:
  - `empty[grant]` is low;
  - `occ + inflight < 4`;
  - `almost_empty[grant]` is low, or no read was issued to this channel in the previous cycle. Back-to-back reads are allowed only on a deep FIFO; a shallow FIFO gets one read, then a gap.
- `beat_cnt` increments on every issued read.
- Each issued read sets `inflight = 1` and stores `inflight_ch` for the next cycle.
- A `rd_data_vld[k]` with `inflight` set and `k == inflight_ch` writes `{k, rd_data[k]}` into the output buffer.
- Any other `rd_data_vld` bit sets `err_unexp`; that data is dropped.
- Output buffer: 4 entries, first-in first-out. A push and a pop in the same cycle are both legal.
- Round-robin pointer `last_grant` resets to N_CH-1, so channel 0 is served first.

## Timing
- Read latency is 1 cycle: `rd` at cycle t gives `rd_data_vld` at t+1 and the buffer write at the end of t+1.
- `out_vld` rises at t+2 for an empty buffer.
- Arbitration costs one IDLE cycle per grant. Burst efficiency is therefore BURST/(BURST+1) when the FIFOs are deep.
- The issue condition does not depend on `out_ready`. There is no combinational path from `out_ready` to `rd`.
- Reset values:
  - `rd = 0`, `out_vld = 0`, `out_data = 0`, `out_ch = 0`, `busy = 0`, `err_unexp = 0`;
  - FSM in IDLE;
  - `occ = 0`, `inflight = 0`, `last_grant = N_CH-1`.
- Reset mid-burst: all state clears immediately, and the buffered and in-flight words are discarded. The FIFOs are assumed reset by the same reset.
- `occ + inflight` never exceeds 4, so the buffer cannot overflow.

## Structure
- Package `fifo_sched_pkg` holds:
  - the state enum `{IDLE, GRANT}`;
  - `OBUF_DEPTH = 4`;
  - the channel-index width constant;
  - the typedef of an output-buffer entry (`ch`, `data`).
- One sub-module, `fifo_rd_obuf`: a 4-deep synchronous FIFO of entries with push/pop/occ. The FSM, round-robin logic and issue logic stay in the top module.

## Test plan
- Single channel: channel 0 holds 10 words and `almost_empty` is low until 3 remain; `out_ready = 1`.
  - Required: bursts of 4, 4, then 2.
  - Required: back-to-back reads only while `almost_empty` is low.
  - Required: `out_ch = 0`, with data in write order.
- Round-robin: all 4 channels hold 8 words each.
  - Required grant order: 0, 1, 2, 3, 0, 1, 2, 3.
  - Required: each burst is exactly 4 beats, with a 1-cycle IDLE gap between bursts.
- Backpressure: `out_ready = 0` for 20 cycles with channel 1 full.
  - Required: exactly 4 reads are issued, then `rd` stays 0 and `out_vld` stays 1.
  - Required: after release, the 32 words drain in order with none lost.
- Shallow FIFO: channel 2 holds 2 words with `almost_empty = 1`.
  - Required: `rd` at t, no read at t+1, `rd` at t+2.
  - Required: the FSM returns to IDLE when `empty` rises.
- Fault and reset cases:
  - Inject `rd_data_vld[3]` with no read outstanding: `err_unexp` goes to 1 and stays 1 until reset.
  - Assert `rd_rstn = 1` mid-burst: all outputs go to their reset values in the same cycle.
- Random soak: 1e4 words over 4 channels with random `out_ready`.
  - Required: each channel's output sequence matches its write sequence.
  - Required: `err_unexp` stays 0, and `rd` is never asserted while `empty` is high.
